mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit of the MIPS datapath. It consumes the ALU result as an effective address, together with the rt operand and the low opcode bits. It then performs one aligned byte, halfword or word access on a word-wide data-memory port with a req/ack handshake and variable wait states. It returns sign- or zero-extended load data, or an error code, with a one-cycle `done` pulse.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` stays high without `mem_ack` before a bus error. 0 disables the timeout.
- `clk  in  1`: rising-edge clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `start  in  1`: launch an access; sampled only in IDLE.
- `op  in  4`: opcode[3:0]. Bit 3 = store, bit 2 = unsigned, bits [1:0] = size (00 byte, 01 half, 11 word).
- `addr  in  32`: effective address (ALU `y`).
- `wdata  in  32`: store data (rt).
- `busy  out  1`: high while not IDLE.
- `done  out  1`: one-cycle completion pulse.
- `err  out  2`: 00 ok, 01 misaligned, 10 timeout, 11 illegal op. Valid with `done` and held until the next `done`.
- `rdata  out  32`: extended load data. Updated only on a successful load `done`, otherwise held.
- `mem_req  out  1`, `mem_we  out  1`, `mem_addr  out  32`, `mem_be  out  4`, `mem_wdata  out  32`: memory request.
- `mem_ack  in  1`, `mem_rdata  in  32`: memory response.

## Operation
- FSM states:
  - IDLE. `start` goes to CHECK.
  - CHECK: one cycle that decodes and registers the request. On error it goes to DONE. Otherwise it goes to REQ.
  - REQ: stays until `mem_ack`, or until the timeout expires. Then goes to DONE.
  - DONE: pulses `done`, then goes to IDLE.
- `start` while `busy` is ignored. `start` and `op`/`addr`/`wdata` are captured in the IDLE cycle where `start`=1. Later input changes have no effect.
- Illegal op: size 10, or store with bit 2 set. Sets `err`=11 and issues no memory request.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠00. Sets `err`=01 and issues no memory request. The illegal-op check has priority over the misalignment check.
- `mem_addr` = {addr[31:2],2'b00}. Byte lanes are little-endian; lane index is addr[1:0].
- `mem_be` for stores and loads alike:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- `mem_wdata` replicates the source: byte is {4{wdata[7:0]}}, half is {2{wdata[15:0]}}, word is wdata.
- Loads: select the byte or half from `mem_rdata` by lane. Sign-extend unless bit 2 is set (zero-extend). `mem_rdata` is captured in the ack cycle.
- Timeout: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches `TIMEOUT` with no ack, `mem_req` drops and `err`=10. An ack arriving in that same cycle wins and gives `err`=00.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset: state IDLE. All outputs are 0: `busy`, `done`, `err`, `rdata`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`. The timeout counter is 0.
- With `start` at cycle 0: CHECK is cycle 1, `mem_req` rises in cycle 2.
- With ack in cycle 2+k (k wait states): `done` is in cycle 3+k and `busy` falls in cycle 4+k. Minimum latency is start→done = 3 cycles.
- Error from CHECK: `done` in cycle 2 with no `mem_req`.
- All memory-side outputs are registered and stable while `mem_req`=1. The request completes in the cycle where `mem_req` and `mem_ack` are both 1. `mem_req` is 0 in the following cycle.
- Back-to-back: the next `start` is accepted in the cycle after `done`.
- `rst_n` low mid-access drops `mem_req` and returns the block to its reset state immediately. No `done` is produced.

## Structure
- Package `mem_pkg`:
  - `op` field positions and size codes (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11)
  - `err` codes (ERR_OK, ERR_ALIGN, ERR_TIMEOUT, ERR_ILLEGAL)
  - FSM state enum
- Sub-module `load_align`: purely combinational; inputs `mem_rdata`, addr[1:0], size, unsigned; output is the extended 32-bit value. The store lane/byte-enable generation stays in the top module.

## Test plan
- lw addr=0x0000_0104, memory returns 0xDEADBEEF after 2 wait states → `mem_be`=1111, `mem_addr`=0x104, `done` at cycle 5, `rdata`=0xDEADBEEF, `err`=00.
- lb addr=0x...03 and lbu addr=0x...03, `mem_rdata`=0x80FF_0000 → `mem_be`=1000; lb gives `rdata`=0xFFFF_FF80, lbu gives 0x0000_0080.
- sh addr=0x...02, wdata=0x1234_ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD.
- lw addr=0x...02 → `done` at cycle 2, `err`=01, `mem_req` never asserted. op=4'b0010 → `err`=11.
- TIMEOUT=4 with no ack → `mem_req` high 4 cycles, then `done` with `err`=10. Repeat with ack on the 4th cycle → `err`=00.
- `rst_n` pulsed low during REQ → all outputs 0 immediately, no `done`. A new lw after release completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: opcode fields, size and error codes, and FSM states shared by the load/store unit.
package mem_pkg;
  localparam int OP_STORE = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a memory word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = 8'(mem_rdata >> {addr, 3'b000});
    h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    data = size == SZ_WORD ? mem_rdata :
           size == SZ_HALF ? {{16{~uns & h[15]}}, h} : {{24{~uns & b[7]}}, b};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit issuing one aligned access per start over a req/ack port.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [3:0] op_q;
  logic [31:0] addr_q, wdata_q, ld, wd_n;
  logic [CW-1:0] cnt;
  logic [1:0] size;
  logic [3:0] be_n;
  logic illegal, misal, expired;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  load_align u_align (
    .mem_rdata(mem_rdata),
    .addr(addr_q[1:0]),
    .size(size),
    .uns(op_q[OP_UNS]),
    .data(ld)
  );
  always_comb begin
    size = op_q[1:0];
    illegal = size == 2'b10 || (op_q[OP_STORE] && op_q[OP_UNS]);
    misal = (size == SZ_HALF && addr_q[0]) || (size == SZ_WORD && addr_q[1:0] != 2'b00);
    expired = TIMEOUT != 0 && 32'(cnt) == TIMEOUT - 32'd1;
    be_n = size == SZ_WORD ? 4'hf : size == SZ_HALF ? (addr_q[1] ? 4'hc : 4'h3) : 4'b0001 << addr_q[1:0];
    wd_n = size == SZ_WORD ? wdata_q : size == SZ_HALF ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    state_nxt = state == S_IDLE  ? (start ? S_CHECK : S_IDLE) :
                state == S_CHECK ? (illegal || misal ? S_DONE : S_REQ) :
                state == S_REQ   ? (mem_ack || expired ? S_DONE : S_REQ) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      err <= ERR_OK;
      rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        op_q <= op;
        addr_q <= addr;
        wdata_q <= wdata;
      end
      if (state == S_CHECK) begin
        cnt <= '0;
        if (illegal) err <= ERR_ILLEGAL;
        else if (misal) err <= ERR_ALIGN;
        else begin
          mem_req <= 1'b1;
          mem_we <= op_q[OP_STORE];
          mem_addr <= {addr_q[31:2], 2'b00};
          mem_be <= be_n;
          mem_wdata <= wd_n;
        end
      end
      // an ack in the expiry cycle still completes the access normally
      if (state == S_REQ) begin
        if (mem_ack || expired) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          mem_addr <= '0;
          mem_be <= '0;
          mem_wdata <= '0;
          err <= mem_ack ? ERR_OK : ERR_TIMEOUT;
          if (mem_ack && !op_q[OP_STORE]) rdata <= ld;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
